// File: rtl/color_roll_if.sv
// Handshake bundle between the game FSM / color detector and the roll controller.
interface color_roll_if;
    logic        roll_start;
    logic        roll_abort;
    logic        color_valid;
    logic [1:0]  dominant_color;
    logic [15:0] color_confidence;
    logic        move_valid;
    logic        move_ready;
    logic [1:0]  move_steps;
    logic [15:0] locked_confidence;
    logic        busy;
    logic        timeout;
    logic [1:0]  state;

    modport master (
        output roll_start, roll_abort, color_valid, dominant_color, color_confidence, move_ready,
        input  move_valid, move_steps, locked_confidence, busy, timeout, state
    );

    modport slave (
        input  roll_start, roll_abort, color_valid, dominant_color, color_confidence, move_ready,
        output move_valid, move_steps, locked_confidence, busy, timeout, state
    );
endinterface

// File: rtl/color_roll_controller.sv
// Debounces per-frame color detections into a single locked move, with timeout and abort.
module color_roll_controller #(
    parameter int unsigned STABLE_FRAMES  = 4,
    parameter logic [15:0] MIN_CONFIDENCE = 16'd200,
    parameter logic [7:0]  TIMEOUT_FRAMES = 8'd120
) (
    input logic         clk,
    input logic         reset,
    color_roll_if.slave bus
);
    localparam logic [3:0] StableTarget = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSettle = 2'b01,
        StIssue  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  candidate_q, candidate_d;
    logic [3:0]  stable_cnt_q, stable_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        move_valid_q, move_valid_d;
    logic [1:0]  move_steps_q, move_steps_d;
    logic [15:0] locked_conf_q, locked_conf_d;
    logic        timeout_q, timeout_d;

    logic        qualify;
    logic [7:0]  frame_nxt;
    logic [3:0]  stable_nxt;
    logic [1:0]  candidate_nxt;

    assign qualify = bus.color_valid && (bus.dominant_color != 2'b00) &&
                     (bus.color_confidence >= MIN_CONFIDENCE);

    // Counter updates a SETTLE frame would produce; only committed when color_valid is seen.
    always_comb begin
        frame_nxt     = (frame_cnt_q == 8'hff) ? 8'hff : frame_cnt_q + 8'd1;
        stable_nxt    = 4'd0;
        candidate_nxt = 2'b00;
        if (qualify) begin
            candidate_nxt = bus.dominant_color;
            if (bus.dominant_color == candidate_q) begin
                stable_nxt = (stable_cnt_q == 4'hf) ? 4'hf : stable_cnt_q + 4'd1;
            end else begin
                stable_nxt = 4'd1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        candidate_d   = candidate_q;
        stable_cnt_d  = stable_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        move_valid_d  = move_valid_q;
        move_steps_d  = move_steps_q;
        locked_conf_d = locked_conf_q;
        timeout_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.roll_start && !bus.roll_abort) begin
                    state_d      = StSettle;
                    candidate_d  = 2'b00;
                    stable_cnt_d = 4'd0;
                    frame_cnt_d  = 8'd0;
                end
            end
            StSettle: begin
                if (bus.roll_abort) begin
                    state_d = StIdle;
                end else if (bus.color_valid) begin
                    frame_cnt_d  = frame_nxt;
                    stable_cnt_d = stable_nxt;
                    candidate_d  = candidate_nxt;
                    // Lock is checked first so it wins over a coincident timeout.
                    if (qualify && stable_nxt == StableTarget) begin
                        state_d       = StIssue;
                        move_valid_d  = 1'b1;
                        move_steps_d  = candidate_nxt;
                        locked_conf_d = bus.color_confidence;
                    end else if (frame_nxt == TIMEOUT_FRAMES) begin
                        state_d   = StIdle;
                        timeout_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                // A coincident ready completes delivery; abort alone drops the move.
                if ((move_valid_q && bus.move_ready) || bus.roll_abort) begin
                    state_d      = StIdle;
                    move_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            candidate_q   <= 2'b00;
            stable_cnt_q  <= 4'd0;
            frame_cnt_q   <= 8'd0;
            move_valid_q  <= 1'b0;
            move_steps_q  <= 2'b00;
            locked_conf_q <= 16'd0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            candidate_q   <= candidate_d;
            stable_cnt_q  <= stable_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            move_valid_q  <= move_valid_d;
            move_steps_q  <= move_steps_d;
            locked_conf_q <= locked_conf_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.move_valid        = move_valid_q;
    assign bus.move_steps        = move_steps_q;
    assign bus.locked_confidence = locked_conf_q;
    assign bus.timeout           = timeout_q;
    assign bus.state             = state_q;
    assign bus.busy              = (state_q != StIdle);
endmodule
